// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// One microstate per clock: it steps the PC/IR enables and the register file
// and memory write enables, and drives the datapath mux selects and ALU
// control from op, funct and the ALU zero flag.
module mips_multicycle_ctrl #(
    parameter int STATE_W = 4   // width of the debug state output, at least 4
) (
    input  logic               clk,
    input  logic               reset,      // asynchronous, active-low
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic               irwrite,
    output logic               regwrite,
    output logic               memwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_reg;
    state_t     state_next;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    // State register; reset drops straight back to FETCH without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
                    default:      state_next = FETCH;   // unknown op acts as a NOP
                endcase
            end
            MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next = MEMWB;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    // Moore outputs per state; write enables are gated off while in reset.
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        case (state_reg)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:  regwrite = 1'b1;
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: ;
        endcase

        // zero only matters through branch, which is set in BEQEX alone.
        pcen = pcwrite | (branch & zero);

        if (!reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

    // ALU decoder: aluop selects fixed add/sub or a funct-driven operation.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign state = STATE_W'(state_reg);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed instruction walks
// plus randomized instruction streams against a per-instruction model.
module tb_mips_multicycle_ctrl;

    localparam int STATE_W = 4;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic               clk;
    logic               reset;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               pcen, irwrite, regwrite, memwrite;
    logic               iord, memtoreg, regdst, alusrca;
    logic [1:0]         alusrcb, pcsrc;
    logic [2:0]         alucontrol;
    logic [STATE_W-1:0] state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mips_multicycle_ctrl #(.STATE_W(STATE_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of every control output, in a fixed order for comparison.
    function automatic logic [14:0] actual_ctrl();
        return {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
                alusrca, alusrcb, pcsrc, alucontrol};
    endfunction

    // ALU operation an R-type instruction asks for.
    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;   // sub
            6'b100100: return 3'b000;   // and
            6'b100101: return 3'b001;   // or
            6'b101010: return 3'b111;   // slt
            default:   return 3'b010;   // add, and anything unknown
        endcase
    endfunction

    // Expected outputs for a microstate number, straight from the state table.
    function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] f,
                                             input logic z, input logic rst_n);
        logic pc_e, ir_w, rf_w, m_w, a_sel, wb_sel, d_sel, a_src;
        logic [1:0] b_src, p_src;
        logic [2:0] alu;
        {pc_e, ir_w, rf_w, m_w, a_sel, wb_sel, d_sel, a_src} = '0;
        b_src = 2'b00;
        p_src = 2'b00;
        alu   = 3'b010;
        case (st)
            0:  begin ir_w = 1; pc_e = 1; b_src = 2'b01; end
            1:  b_src = 2'b11;
            2:  begin a_src = 1; b_src = 2'b10; end
            3:  a_sel = 1;
            4:  begin rf_w = 1; wb_sel = 1; end
            5:  begin a_sel = 1; m_w = 1; end
            6:  begin a_src = 1; alu = rtype_alu(f); end
            7:  begin rf_w = 1; d_sel = 1; end
            8:  begin a_src = 1; p_src = 2'b01; alu = 3'b110; pc_e = z; end
            9:  begin a_src = 1; b_src = 2'b10; end
            10: rf_w = 1;
            11: begin pc_e = 1; p_src = 2'b10; end
            default: ;
        endcase
        if (!rst_n) begin
            pc_e = 0; ir_w = 0; rf_w = 0; m_w = 0;
        end
        return {pc_e, ir_w, rf_w, m_w, a_sel, wb_sel, d_sel, a_src, b_src, p_src, alu};
    endfunction

    // Microstate sequence an instruction walks through, FETCH first.
    task automatic seq_for(input logic [5:0] o, output int seq[6], output int n);
        for (int i = 0; i < 6; i++) seq[i] = 0;
        case (o)
            OP_LW:    begin seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 4;  n = 5; end
            OP_SW:    begin seq[1] = 1; seq[2] = 2; seq[3] = 5;              n = 4; end
            OP_RTYPE: begin seq[1] = 1; seq[2] = 6; seq[3] = 7;              n = 4; end
            OP_ADDI:  begin seq[1] = 1; seq[2] = 9; seq[3] = 10;             n = 4; end
            OP_BEQ:   begin seq[1] = 1; seq[2] = 8;                          n = 3; end
            OP_J:     begin seq[1] = 1; seq[2] = 11;                         n = 3; end
            default:  begin seq[1] = 1;                                      n = 2; end
        endcase
    endtask

    // Runs one instruction from FETCH, checking every cycle. zero is random
    // except in BEQEX, where it is beq_zero; it is then flipped mid-cycle to
    // confirm pcen follows it only where it should.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic beq_zero, input string name);
        int seq[6];
        int n;
        logic [14:0] exp;
        seq_for(o, seq, n);
        op    = o;
        funct = f;
        for (int i = 0; i < n; i++) begin
            zero = (seq[i] == 8) ? beq_zero : 1'($urandom_range(0, 1));
            #1;
            total_cnt++;
            if (state !== STATE_W'(seq[i]))
                $display("FAIL %s state cyc%0d: got %0d want %0d", name, i, state, seq[i]);
            else pass_cnt++;
            exp = exp_ctrl(seq[i], f, zero, 1'b1);
            total_cnt++;
            if (actual_ctrl() !== exp)
                $display("FAIL %s ctrl cyc%0d st%0d: got %b want %b", name, i, seq[i], actual_ctrl(), exp);
            else pass_cnt++;
            zero = ~zero;
            #1;
            exp = exp_ctrl(seq[i], f, zero, 1'b1);
            total_cnt++;
            if (pcen !== exp[14])
                $display("FAIL %s pcen_zero_toggle cyc%0d st%0d: got %b want %b", name, i, seq[i], pcen, exp[14]);
            else pass_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        $display("instr %s op=%b funct=%b cycles=%0d", name, o, f, n);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        op    = OP_LW;
        funct = 6'b0;
        zero  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (state !== '0) $display("FAIL reset_state: got %0d want 0", state);
        else pass_cnt++;
        total_cnt++;
        if (actual_ctrl() !== exp_ctrl(0, funct, zero, 1'b0))
            $display("FAIL reset_ctrl: got %b want %b", actual_ctrl(), exp_ctrl(0, funct, zero, 1'b0));
        else pass_cnt++;
        $display("reset held 2 cycles");
        reset = 1'b1;
    endtask

    task automatic test_lw();
        run_instr(OP_LW, 6'b0, 1'b0, "lw");
    endtask

    task automatic test_sw();
        run_instr(OP_SW, 6'b0, 1'b0, "sw");
    endtask

    task automatic test_rtype();
        logic [5:0] fl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < 5; i++) run_instr(OP_RTYPE, fl[i], 1'b0, "rtype");
    endtask

    task automatic test_beq();
        run_instr(OP_BEQ, 6'b0, 1'b1, "beq_taken");
        run_instr(OP_BEQ, 6'b0, 1'b0, "beq_not_taken");
    endtask

    task automatic test_addi_j_illegal();
        run_instr(OP_ADDI, 6'b0, 1'b0, "addi");
        run_instr(OP_J, 6'b0, 1'b0, "j");
        run_instr(6'b111111, 6'b0, 1'b0, "illegal");
    endtask

    // Reset pulled low between edges during MEMWR must act without a clock.
    task automatic test_async_reset_midop();
        logic [14:0] exp;
        op    = OP_SW;
        funct = 6'b0;
        zero  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        total_cnt++;
        if (!(state === 4'd5 && memwrite === 1'b1))
            $display("FAIL async_pre_memwr: got state %0d memwrite %b want 5/1", state, memwrite);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (state !== '0) $display("FAIL async_state: got %0d want 0", state);
        else pass_cnt++;
        exp = exp_ctrl(0, funct, zero, 1'b0);
        total_cnt++;
        if (actual_ctrl() !== exp)
            $display("FAIL async_ctrl: got %b want %b", actual_ctrl(), exp);
        else pass_cnt++;
        $display("async reset during MEMWR");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_instr(OP_LW, 6'b0, 1'b0, "lw_after_reset");
    endtask

    // Random instruction stream, back to back.
    task automatic test_random();
        logic [5:0] legal[6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
        logic [5:0] fl[5]    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] o, f;
        bit is_legal;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do begin
                    o = 6'($urandom);
                    is_legal = 0;
                    for (int j = 0; j < 6; j++) if (o == legal[j]) is_legal = 1;
                end while (is_legal);
            end else begin
                o = legal[$urandom_range(0, 5)];
            end
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 4)];
            run_instr(o, f, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_addi_j_illegal();
        test_async_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
